// File: rtl/pipeline_hazard_control_pkg.sv
// Shared state encodings and pipe-control vectors for the hazard controller.
package pipeline_hazard_control_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_RUN        = 3'd1,
        ST_LOAD_STALL = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_MEM_WAIT   = 3'd4
    } hz_state_t;

    // One bundle of pipe-register controls driven in a given cycle.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic flush;
        logic bubble;
        logic hold;
    } hz_ctrl_t;

    // Remaining-cycle counter width; covers FLUSH_CYCLES / LOAD_STALL_CYCLES up to 3.
    localparam int HZ_CNT_WIDTH = 2;

    localparam hz_ctrl_t CTRL_INIT  = '{pc_we: 1'b0, if_id_we: 1'b0, flush: 1'b1, bubble: 1'b1, hold: 1'b0};
    localparam hz_ctrl_t CTRL_RUN   = '{pc_we: 1'b1, if_id_we: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b0};
    localparam hz_ctrl_t CTRL_STALL = '{pc_we: 1'b0, if_id_we: 1'b0, flush: 1'b0, bubble: 1'b1, hold: 1'b0};
    localparam hz_ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, if_id_we: 1'b1, flush: 1'b1, bubble: 1'b1, hold: 1'b0};
    localparam hz_ctrl_t CTRL_HOLD  = '{pc_we: 1'b0, if_id_we: 1'b0, flush: 1'b0, bubble: 1'b0, hold: 1'b1};

endpackage

// File: rtl/pipeline_hazard_control_compare.sv
// Load-use address comparator: flags an ID instruction that reads the register
// an EX-stage load is about to write. Register 0 is hardwired and never hazards.
module pipeline_hazard_control_compare #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
    input  logic                      i_imm_inst,
    input  logic                      i_ex_load,
    input  logic                      i_ex_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_wr_addr,
    output logic                      o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_nonzero = (i_ex_wr_addr != '0);
    assign w_rs1_hit    = (i_ex_wr_addr == i_rs1);
    // rs2 is not read by immediate-type instructions, so it cannot hazard.
    assign w_rs2_hit    = !i_imm_inst && (i_ex_wr_addr == i_rs2);

    assign o_load_use = i_id_valid && i_ex_load && i_ex_wr_en && w_rd_nonzero
                        && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_control.sv
// IF/ID/EX hazard sequencer: load-use stalls, redirect flushes, memory-busy
// freezes, plus a saturating count of cycles the PC was held.
//
//   state       | meaning
//   INIT        | reset / first cycle after; pipe loads NOPs, PC held
//   RUN         | normal flow
//   LOAD_STALL  | extra load-use bubble cycles while r_cnt > 0
//   FLUSH       | extra redirect flush cycles while r_cnt > 0
//   MEM_WAIT    | data memory busy; r_cnt and r_held preserved for resume
module pipeline_hazard_control
    import pipeline_hazard_control_pkg::*;
#(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STALL_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0]  id_read_address1_in,
    input  logic [REG_ADDR_WIDTH-1:0]  id_read_address2_in,
    input  logic                       id_imm_inst_in,
    input  logic                       ex_mem_data_rd_en_in,
    input  logic                       ex_reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_reg_wr_addr_in,
    input  logic                       ex_branch_taken_in,
    input  logic                       ex_jump_inst_in,
    input  logic                       mem_busy_in,
    output logic                       pc_write_en_out,
    output logic                       if_id_write_en_out,
    output logic                       if_id_flush_out,
    output logic                       id_ex_bubble_out,
    output logic                       ex_mem_hold_out,
    output logic [2:0]                 state_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_out
);

    localparam logic [HZ_CNT_WIDTH-1:0] FLUSH_RELOAD = HZ_CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [HZ_CNT_WIDTH-1:0] LOAD_RELOAD  = HZ_CNT_WIDTH'(LOAD_STALL_CYCLES - 1);
    localparam logic [HZ_CNT_WIDTH-1:0] CNT_ONE      = HZ_CNT_WIDTH'(1);
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1);

    hz_state_t                   r_state;
    hz_state_t                   r_held;
    logic [HZ_CNT_WIDTH-1:0]     r_cnt;
    logic [STALL_CNT_WIDTH-1:0]  r_stall_cnt;

    hz_state_t                   w_eff;
    hz_state_t                   w_next_state;
    hz_state_t                   w_next_held;
    logic [HZ_CNT_WIDTH-1:0]     w_next_cnt;
    hz_ctrl_t                    w_ctrl;
    logic                        w_redirect;
    logic                        w_load_use;

    pipeline_hazard_control_compare #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_compare (
        .i_id_valid   (id_valid_in),
        .i_rs1        (id_read_address1_in),
        .i_rs2        (id_read_address2_in),
        .i_imm_inst   (id_imm_inst_in),
        .i_ex_load    (ex_mem_data_rd_en_in),
        .i_ex_wr_en   (ex_reg_wr_en_in),
        .i_ex_wr_addr (ex_reg_wr_addr_in),
        .o_load_use   (w_load_use)
    );

    assign w_redirect = ex_branch_taken_in || ex_jump_inst_in;

    // State the controller behaves as this cycle; MEM_WAIT resumes whatever was interrupted.
    always_comb begin
        w_eff = r_state;
        if (r_state == ST_MEM_WAIT) begin
            w_eff = (r_cnt != '0) ? r_held : ST_RUN;
        end
    end

    // Next-state and output decode, priority mem_busy > redirect > pending/new load-use.
    always_comb begin
        w_ctrl       = CTRL_RUN;
        w_next_state = ST_RUN;
        w_next_cnt   = '0;
        w_next_held  = r_held;
        if (r_state == ST_INIT) begin
            w_ctrl = CTRL_INIT;
        end else if (mem_busy_in) begin
            w_ctrl       = CTRL_HOLD;
            w_next_state = ST_MEM_WAIT;
            w_next_cnt   = r_cnt;
            if (r_state != ST_MEM_WAIT) begin
                w_next_held = w_eff;
            end
        end else if (w_redirect) begin
            w_ctrl = CTRL_FLUSH;
            if (FLUSH_CYCLES > 1) begin
                w_next_state = ST_FLUSH;
                w_next_cnt   = FLUSH_RELOAD;
            end
        end else if (w_eff == ST_FLUSH) begin
            w_ctrl       = CTRL_FLUSH;
            w_next_cnt   = r_cnt - CNT_ONE;
            w_next_state = (r_cnt == CNT_ONE) ? ST_RUN : ST_FLUSH;
        end else if ((w_eff == ST_LOAD_STALL) && (r_cnt != '0)) begin
            w_ctrl       = CTRL_STALL;
            w_next_cnt   = r_cnt - CNT_ONE;
            w_next_state = ST_LOAD_STALL;
        end else if (w_load_use) begin
            w_ctrl       = CTRL_STALL;
            w_next_cnt   = LOAD_RELOAD;
            w_next_state = ST_LOAD_STALL;
        end
    end

    // State, remaining-cycle counter and resume target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_held  <= ST_RUN;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_held  <= w_next_held;
        end
    end

    // Saturating count of post-INIT cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state != ST_INIT) && !w_ctrl.pc_we && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

    assign pc_write_en_out    = w_ctrl.pc_we;
    assign if_id_write_en_out = w_ctrl.if_id_we;
    assign if_id_flush_out    = w_ctrl.flush;
    assign id_ex_bubble_out   = w_ctrl.bubble;
    assign ex_mem_hold_out    = w_ctrl.hold;
    assign state_out          = r_state;
    assign stall_cycles_out   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Self-checking bench for pipeline_hazard_control: directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_pipeline_hazard_control;

    localparam int RAW = 5;
    localparam int FC  = 2;
    localparam int LC  = 2;
    localparam int SW  = 5;
    localparam int SAT = (1 << SW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           id_valid, imm, ex_load, ex_wr_en, br, jmp, busy;
    logic [RAW-1:0] rs1, rs2, ex_wr_addr;
    logic           pc_we, if_id_we, flush, bubble, hold;
    logic [2:0]     st;
    logic [SW-1:0]  stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: state number, remaining extra cycles, interrupted state, stall count.
    int m_state, m_left, m_held, m_stall;

    always #5 clk = ~clk;

    pipeline_hazard_control #(
        .REG_ADDR_WIDTH    (RAW),
        .FLUSH_CYCLES      (FC),
        .LOAD_STALL_CYCLES (LC),
        .STALL_CNT_WIDTH   (SW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .id_valid_in          (id_valid),
        .id_read_address1_in  (rs1),
        .id_read_address2_in  (rs2),
        .id_imm_inst_in       (imm),
        .ex_mem_data_rd_en_in (ex_load),
        .ex_reg_wr_en_in      (ex_wr_en),
        .ex_reg_wr_addr_in    (ex_wr_addr),
        .ex_branch_taken_in   (br),
        .ex_jump_inst_in      (jmp),
        .mem_busy_in          (busy),
        .pc_write_en_out      (pc_we),
        .if_id_write_en_out   (if_id_we),
        .if_id_flush_out      (flush),
        .id_ex_bubble_out     (bubble),
        .ex_mem_hold_out      (hold),
        .state_out            (st),
        .stall_cycles_out     (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; imm = 0; ex_load = 0; ex_wr_en = 0; br = 0; jmp = 0; busy = 0;
        rs1 = '0; rs2 = '0; ex_wr_addr = '0;
    endtask

    task automatic model_reset();
        m_state = 0; m_left = 0; m_held = 1; m_stall = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("rst.state", st, 0);
        check("rst.ctrl", {pc_we, if_id_we, flush, bubble, hold}, 5'b00110);
        check("rst.stall", stall, 0);
        rst_n = 1'b1;
    endtask

    // One cycle: predict outputs from current inputs, compare at negedge, advance at posedge.
    // ctrl bits are {pc_we, if_id_we, flush, bubble, hold}.
    task automatic step(input string tag);
        int  e_ctrl, n_state, n_left, n_held, eff;
        bit  lu, rd;
        @(negedge clk);
        lu = id_valid && ex_load && ex_wr_en && (ex_wr_addr != 0)
             && ((ex_wr_addr == rs1) || (!imm && (ex_wr_addr == rs2)));
        rd = br || jmp;
        eff = m_state;
        if (m_state == 4) eff = (m_left != 0) ? m_held : 1;
        n_state = 1; n_left = 0; n_held = m_held;
        if (m_state == 0) begin
            e_ctrl = 5'b00110;
        end else if (busy) begin
            e_ctrl = 5'b00001; n_state = 4; n_left = m_left;
            if (m_state != 4) n_held = eff;
        end else if (rd) begin
            e_ctrl = 5'b11110;
            if (FC > 1) begin n_state = 3; n_left = FC - 1; end
        end else if (eff == 3) begin
            e_ctrl = 5'b11110; n_left = m_left - 1; n_state = (n_left == 0) ? 1 : 3;
        end else if (eff == 2 && m_left > 0) begin
            e_ctrl = 5'b00010; n_left = m_left - 1; n_state = 2;
        end else if (lu) begin
            e_ctrl = 5'b00010; n_state = 2; n_left = LC - 1;
        end else begin
            e_ctrl = 5'b11000;
        end
        check({tag, ".state"}, st, m_state);
        check({tag, ".ctrl"}, {pc_we, if_id_we, flush, bubble, hold}, e_ctrl);
        check({tag, ".stall"}, stall, m_stall);
        @(posedge clk);
        if (m_state != 0 && e_ctrl[4] == 0 && m_stall < SAT) m_stall++;
        m_state = n_state; m_left = n_left; m_held = n_held;
        #1;
    endtask

    initial begin
        clear_inputs();
        #2;
        do_reset();

        // Reset release: one INIT cycle, then RUN.
        step("t1_init");
        step("t1_run");
        check("t1_pc_we", pc_we, 1);

        // Load r3 in EX, add r4,r3,r5 in ID.
        id_valid = 1; rs1 = 3; rs2 = 5; ex_load = 1; ex_wr_en = 1; ex_wr_addr = 3;
        step("t2_hit");
        ex_load = 0; ex_wr_en = 0; ex_wr_addr = 0;
        for (int i = 0; i < LC; i++) step("t2_stall");
        check("t2_cnt", stall, LC);
        // Immediate-type ID whose unused rs2 matches: no stall.
        imm = 1; rs1 = 5; rs2 = 3; ex_load = 1; ex_wr_en = 1; ex_wr_addr = 3;
        step("t2_imm");
        check("t2_imm_pc", pc_we, 1);

        // Load writing r0 versus rs1=r0: no stall.
        imm = 0; rs1 = 0; rs2 = 7; ex_wr_addr = 0;
        step("t3_r0");

        // Taken branch together with a load-use hit.
        rs1 = 3; ex_wr_addr = 3; br = 1;
        step("t4_redir");
        clear_inputs();
        step("t4_flush2");
        step("t4_run");

        // Memory busy for three cycles in the middle of a two-cycle load stall.
        do_reset();
        step("t5_init");
        id_valid = 1; rs1 = 9; ex_load = 1; ex_wr_en = 1; ex_wr_addr = 9;
        step("t5_hit");
        clear_inputs();
        busy = 1;
        for (int i = 0; i < 3; i++) step("t5_busy");
        busy = 0;
        step("t5_resume");
        step("t5_run");
        check("t5_cnt", stall, 5);

        // Saturation of the stall counter.
        busy = 1;
        for (int i = 0; i < SAT + 4; i++) step("t6_sat");
        check("t6_sat_val", stall, SAT);
        busy = 0;
        step("t6_run");

        // Reset pulsed in the middle of a flush.
        jmp = 1;
        step("t6_redir");
        jmp = 0;
        check("t6_in_flush", st, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", st, 0);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_ctrl", {pc_we, if_id_we, flush, bubble, hold}, 5'b00110);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("t6_init");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            busy       = ($urandom_range(0, 99) < 12);
            br         = ($urandom_range(0, 99) < 7);
            jmp        = ($urandom_range(0, 99) < 4);
            id_valid   = ($urandom_range(0, 99) < 85);
            imm        = ($urandom_range(0, 99) < 30);
            ex_load    = ($urandom_range(0, 99) < 45);
            ex_wr_en   = ($urandom_range(0, 99) < 80);
            rs1        = RAW'($urandom_range(0, 3));
            rs2        = RAW'($urandom_range(0, 3));
            ex_wr_addr = RAW'($urandom_range(0, 3));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
